// File: rtl/fixed_latency_issuer.sv
// Initiator for fixed-latency operators: issues operand pairs with a one-cycle tstart pulse
// and collects each result LATENCY cycles later into an in-order, credit-protected buffer.
module fixed_latency_issuer #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned DEPTH   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] unit_in1,
    output logic [WIDTH-1:0] unit_in2,
    output logic             unit_tstart,
    input  logic [WIDTH-1:0] unit_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam int unsigned CW = $clog2(DEPTH + LATENCY + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [LATENCY-1:0] track_q, track_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [CW-1:0]      inflight;
    logic [CW-1:0]      used;
    logic               fire;
    logic               capture;
    logic               pop;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < LATENCY; i++) begin
            inflight = inflight + CW'(track_q[i]);
        end
    end

    // Credits come from registered state only, so a pop frees a slot one cycle later.
    assign used        = count_q + inflight;
    assign in_ready    = rst_n & (used < CW'(DEPTH));
    assign fire        = in_valid & in_ready;

    assign unit_tstart = fire;
    assign unit_in1    = in_a;
    assign unit_in2    = in_b;

    assign capture     = track_q[LATENCY-1];
    assign out_valid   = (count_q != '0);
    assign pop         = out_valid & out_ready;
    assign out_data    = out_valid ? mem_q[rd_ptr_q] : '0;
    assign busy        = (track_q != '0) | out_valid;

    always_comb begin
        track_d  = (track_q << 1) | LATENCY'(fire);
        wr_ptr_d = capture ? wrap_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? wrap_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CW'(capture) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            track_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            track_q  <= track_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: out_data is masked while the buffer is empty.
    always_ff @(posedge clk) begin
        if (capture) begin
            mem_q[wr_ptr_q] <= unit_out;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(capture && (count_q == CW'(DEPTH))));

endmodule

// File: tb/tb_fixed_latency_issuer.sv
// Bench for fixed_latency_issuer: directed tables on a mult (LATENCY=2) and add (LATENCY=1)
// instance, then random valid/ready traffic on five configurations against a scoreboard.
module tb_fixed_latency_issuer;

    localparam int W    = 32;
    localparam int N    = 5;
    localparam int NOPS = 1000;

    function automatic int lat_of(input int i);
        case (i)
            0:       return 2;
            1:       return 1;
            2:       return 1;
            3:       return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int dep_of(input int i);
        case (i)
            0:       return 4;
            1:       return 4;
            2:       return 3;
            3:       return 1;
            default: return 4;
        endcase
    endfunction

    function automatic logic [W-1:0] op(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input int l);
        return (l == 1) ? a + b : a * b;
    endfunction

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } vec_t;

    typedef struct {
        logic         iv;
        logic [W-1:0] a;
        logic         ordy;
        logic         rdy;
        logic         ov;
        logic [W-1:0] od;
        logic         bsy;
    } step_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n       [N];
    logic         in_valid    [N];
    logic         in_ready    [N];
    logic [W-1:0] in_a        [N];
    logic [W-1:0] in_b        [N];
    logic [W-1:0] unit_in1    [N];
    logic [W-1:0] unit_in2    [N];
    logic         unit_tstart [N];
    logic [W-1:0] unit_out    [N];
    logic         out_valid   [N];
    logic         out_ready   [N];
    logic [W-1:0] out_data    [N];
    logic         busy        [N];
    int           n_tstart    [N];
    int           n_out       [N];
    int           sb_cnt      [N];

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void check(input string name, input logic [W-1:0] act,
                                  input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic void checkb(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b, expected %0b", name, act, exp);
        end
    endfunction

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        localparam int L = lat_of(gi);
        localparam int D = dep_of(gi);

        logic [W-1:0] pipe [L];
        logic [W-1:0] sb [$];
        int           tstart_cnt   = 0;
        int           out_cnt      = 0;
        int           sb_size      = 0;
        logic         stall_q      = 1'b0;
        logic [W-1:0] stall_data_q = '0;

        fixed_latency_issuer #(
            .WIDTH  (W),
            .LATENCY(L),
            .DEPTH  (D)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n[gi]),
            .in_valid   (in_valid[gi]),
            .in_ready   (in_ready[gi]),
            .in_a       (in_a[gi]),
            .in_b       (in_b[gi]),
            .unit_in1   (unit_in1[gi]),
            .unit_in2   (unit_in2[gi]),
            .unit_tstart(unit_tstart[gi]),
            .unit_out   (unit_out[gi]),
            .out_valid  (out_valid[gi]),
            .out_ready  (out_ready[gi]),
            .out_data   (out_data[gi]),
            .busy       (busy[gi])
        );

        // Operator model: result appears L cycles after tstart, garbage otherwise.
        always @(posedge clk) begin
            pipe[0] <= unit_tstart[gi] ? op(unit_in1[gi], unit_in2[gi], L) : $urandom;
            for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
        end
        assign unit_out[gi] = pipe[L-1];

        always @(negedge clk) begin
            if (!rst_n[gi]) begin
                sb.delete();
                stall_q <= 1'b0;
                sb_size <= 0;
            end else begin
                if (stall_q) begin
                    checkb($sformatf("u%0d_hold_valid", gi), out_valid[gi], 1'b1);
                    check($sformatf("u%0d_hold_data", gi), out_data[gi], stall_data_q);
                end
                if (unit_tstart[gi]) tstart_cnt <= tstart_cnt + 1;
                if (out_valid[gi] && out_ready[gi]) begin
                    out_cnt <= out_cnt + 1;
                    if (sb.size() == 0) begin
                        checkb($sformatf("u%0d_spurious_result", gi), out_valid[gi], 1'b0);
                    end else begin
                        check($sformatf("u%0d_result", gi), out_data[gi], sb.pop_front());
                    end
                end
                if (in_valid[gi] && in_ready[gi]) sb.push_back(op(in_a[gi], in_b[gi], L));
                stall_q      <= out_valid[gi] && !out_ready[gi];
                stall_data_q <= out_data[gi];
                sb_size      <= sb.size();
            end
        end

        assign n_tstart[gi] = tstart_cnt;
        assign n_out[gi]    = out_cnt;
        assign sb_cnt[gi]   = sb_size;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t  vecs  [8];
        step_t steps [11];
        logic  add_ts [4];
        logic  add_ov [4];
        logic  add_bs [4];
        int    issued [N];
        logic  fired  [N];
        int    base_t [N];
        int    base_o [N];
        int    cycles;
        logic  done;

        for (int i = 0; i < 8; i++) vecs[i] = '{W'(i), W'(i + 1), W'(i * (i + 1))};
        add_ts = '{1'b1, 1'b0, 1'b0, 1'b0};
        add_ov = '{1'b0, 1'b0, 1'b1, 1'b0};
        add_bs = '{1'b0, 1'b1, 1'b1, 1'b0};
        //           iv    a       ordy  rdy   ov    od      busy
        steps[0]  = '{1'b1, 32'd20, 1'b0, 1'b1, 1'b0, 32'd0,  1'b0};
        steps[1]  = '{1'b1, 32'd21, 1'b0, 1'b1, 1'b0, 32'd0,  1'b1};
        steps[2]  = '{1'b1, 32'd22, 1'b0, 1'b1, 1'b0, 32'd0,  1'b1};
        steps[3]  = '{1'b1, 32'd23, 1'b0, 1'b1, 1'b1, 32'd60, 1'b1};
        steps[4]  = '{1'b1, 32'd24, 1'b1, 1'b0, 1'b1, 32'd60, 1'b1};
        steps[5]  = '{1'b1, 32'd24, 1'b1, 1'b1, 1'b1, 32'd63, 1'b1};
        steps[6]  = '{1'b1, 32'd25, 1'b1, 1'b1, 1'b1, 32'd66, 1'b1};
        steps[7]  = '{1'b0, 32'd0,  1'b1, 1'b1, 1'b1, 32'd69, 1'b1};
        steps[8]  = '{1'b0, 32'd0,  1'b1, 1'b1, 1'b1, 32'd72, 1'b1};
        steps[9]  = '{1'b0, 32'd0,  1'b1, 1'b1, 1'b1, 32'd75, 1'b1};
        steps[10] = '{1'b0, 32'd0,  1'b1, 1'b1, 1'b0, 32'd0,  1'b0};

        for (int i = 0; i < N; i++) begin
            rst_n[i]     = 1'b0;
            in_valid[i]  = 1'b0;
            in_a[i]      = '0;
            in_b[i]      = '0;
            out_ready[i] = 1'b0;
            issued[i]    = 0;
            fired[i]     = 1'b0;
        end
        in_valid[0] = 1'b1;

        // Reset state, with in_valid high to show nothing issues during reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkb("rst_out_valid", out_valid[0], 1'b0);
        check("rst_out_data", out_data[0], '0);
        checkb("rst_busy", busy[0], 1'b0);
        checkb("rst_tstart", unit_tstart[0], 1'b0);
        checkb("rst_in_ready", in_ready[0], 1'b0);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        for (int i = 0; i < N; i++) rst_n[i] = 1'b1;
        @(negedge clk);
        checkb("rel_in_ready", in_ready[0], 1'b1);

        // Back-to-back mult, 8 pairs, out_ready=1: first result at t3, one per cycle
        @(posedge clk); #1;
        out_ready[0] = 1'b1;
        for (int k = 0; k < 11; k++) begin
            in_valid[0] = (k < 8);
            if (k < 8) begin
                in_a[0] = vecs[k].a;
                in_b[0] = vecs[k].b;
            end
            @(negedge clk);
            if (k < 8) checkb($sformatf("b2b_in_ready_%0d", k), in_ready[0], 1'b1);
            if (k < 3) begin
                checkb($sformatf("b2b_early_valid_%0d", k), out_valid[0], 1'b0);
            end else begin
                checkb($sformatf("b2b_out_valid_%0d", k), out_valid[0], 1'b1);
                check($sformatf("b2b_out_data_%0d", k), out_data[0], vecs[k-3].exp);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checkb("b2b_idle_busy", busy[0], 1'b0);

        // Single add, LATENCY=1
        @(posedge clk); #1;
        out_ready[1] = 1'b1;
        for (int t = 0; t < 4; t++) begin
            in_valid[1] = (t == 0);
            in_a[1]     = 32'd3;
            in_b[1]     = 32'd4;
            @(negedge clk);
            checkb($sformatf("add_tstart_t%0d", t), unit_tstart[1], add_ts[t]);
            checkb($sformatf("add_out_valid_t%0d", t), out_valid[1], add_ov[t]);
            check($sformatf("add_out_data_t%0d", t), out_data[1], (t == 2) ? 32'd7 : 32'd0);
            checkb($sformatf("add_busy_t%0d", t), busy[1], add_bs[t]);
            @(posedge clk); #1;
        end

        // Backpressure: 4 issues then stall; drain restores in_ready one cycle after first pop
        out_ready[0] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_valid[0] = 1'b1;
            in_a[0]     = W'(10 + k);
            in_b[0]     = 32'd2;
            @(negedge clk);
            checkb($sformatf("bp_in_ready_%0d", k), in_ready[0], k < 4);
            @(posedge clk); #1;
        end
        in_valid[0] = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        out_ready[0] = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            checkb($sformatf("bp_drain_valid_%0d", j), out_valid[0], j < 4);
            check($sformatf("bp_drain_data_%0d", j), out_data[0],
                  (j < 4) ? W'((10 + j) * 2) : 32'd0);
            checkb($sformatf("bp_drain_in_ready_%0d", j), in_ready[0], j != 0);
            @(posedge clk); #1;
        end

        // Simultaneous capture and pop at 2 entries, crossing the pointer wrap
        for (int k = 0; k < 11; k++) begin
            in_valid[0]  = steps[k].iv;
            in_a[0]      = steps[k].a;
            in_b[0]      = 32'd3;
            out_ready[0] = steps[k].ordy;
            @(negedge clk);
            checkb($sformatf("cp_in_ready_%0d", k), in_ready[0], steps[k].rdy);
            checkb($sformatf("cp_out_valid_%0d", k), out_valid[0], steps[k].ov);
            check($sformatf("cp_out_data_%0d", k), out_data[0], steps[k].od);
            checkb($sformatf("cp_busy_%0d", k), busy[0], steps[k].bsy);
            @(posedge clk); #1;
        end

        // Reset with 2 in flight and 1 buffered; nothing may emerge afterwards
        out_ready[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid[0] = 1'b1;
            in_a[0]     = W'(k + 1);
            in_b[0]     = 32'd5;
            @(negedge clk);
            @(posedge clk); #1;
        end
        in_valid[0] = 1'b0;
        @(negedge clk);
        checkb("rmf_pre_valid", out_valid[0], 1'b1);
        checkb("rmf_pre_busy", busy[0], 1'b1);
        rst_n[0] = 1'b0;
        #1;
        checkb("rmf_out_valid", out_valid[0], 1'b0);
        checkb("rmf_busy", busy[0], 1'b0);
        check("rmf_out_data", out_data[0], '0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n[0]     = 1'b1;
        out_ready[0] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checkb($sformatf("rmf_no_result_%0d", k), out_valid[0], 1'b0);
            @(posedge clk); #1;
        end

        // Random valid/ready traffic on every configuration
        for (int i = 0; i < N; i++) begin
            base_t[i] = n_tstart[i];
            base_o[i] = n_out[i];
        end
        cycles = 0;
        done   = 1'b0;
        while (!done && cycles < 40000) begin
            for (int i = 0; i < N; i++) begin
                if (!(in_valid[i] && !fired[i])) begin
                    in_valid[i] = (issued[i] < NOPS) && ($urandom_range(3) != 0);
                    in_a[i]     = $urandom;
                    in_b[i]     = $urandom;
                end
                out_ready[i] = ($urandom_range(2) != 0);
            end
            @(negedge clk);
            done = 1'b1;
            for (int i = 0; i < N; i++) begin
                fired[i] = in_valid[i] && in_ready[i];
                if (fired[i]) issued[i]++;
                if (issued[i] < NOPS || busy[i]) done = 1'b0;
            end
            @(posedge clk); #1;
            cycles++;
        end
        checkb("rand_completed", done, 1'b1);
        for (int i = 0; i < N; i++) in_valid[i] = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check($sformatf("rand_u%0d_tstart_count", i), W'(n_tstart[i] - base_t[i]), W'(NOPS));
            check($sformatf("rand_u%0d_out_count", i), W'(n_out[i] - base_o[i]), W'(NOPS));
            check($sformatf("rand_u%0d_sb_left", i), W'(sb_cnt[i]), '0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
